// File: rtl/rr_csr_pkg.sv
// Register map and field positions for the record-replay CSR block.
package rr_csr_pkg;
  localparam logic [7:0] RR_ID_OFS        = 8'h00;
  localparam logic [7:0] RR_CTRL_OFS      = 8'h04;
  localparam logic [7:0] RR_STATUS_OFS    = 8'h08;
  localparam logic [7:0] RR_SCRATCH_OFS   = 8'h0C;
  localparam logic [7:0] RR_WR_CNT_OFS    = 8'h10;
  localparam logic [7:0] RR_RD_CNT_OFS    = 8'h14;
  localparam logic [7:0] RR_STALL_CNT_OFS = 8'h18;
  localparam logic [7:0] RR_CYC_LO_OFS    = 8'h1C;
  localparam logic [7:0] RR_CYC_HI_OFS    = 8'h20;

  localparam int CTRL_REC_BIT    = 0;
  localparam int CTRL_REPLAY_BIT = 1;
  localparam int CTRL_CLR_BIT    = 2;
  localparam int STATUS_SAT_BIT  = 2;

  localparam logic [31:0] RR_BAD_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/cfg_bus_t.sv
// Single-pulse cfg_bus between the OCL slave decoder and a register slot.
interface cfg_bus_t;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic        ack;
  logic [31:0] rdata;

  modport slave  (input addr, wdata, wr, rd, output ack, rdata);
  modport master (output addr, wdata, wr, rd, input ack, rdata);
endinterface

// File: rtl/rr_sat_counter.sv
// Event counter that sticks at all-ones; synchronous clear has priority.
module rr_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);
  assign sat = &cnt;

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n)      cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rr_cfg_csr.sv
// RR control/status registers: recorder controls plus activity counters.
module rr_cfg_csr
  import rr_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5252_0001
) (
  input  logic     clk,
  input  logic     sync_rst_n,
  cfg_bus_t.slave  cfg_bus,
  input  logic     evt_wr,
  input  logic     evt_rd,
  input  logic     log_stall,
  output logic     rr_rec_en,
  output logic     rr_replay_en
);
  logic [7:0]  ofs;
  logic        wr, rd, ctrl_wr, clr;
  logic        ack;
  logic [31:0] rdata, rd_mux, scratch, shadow;
  logic [31:0] wr_cnt, rd_cnt, stall_cnt;
  logic [2:0]  sats;
  logic        sat_flag;
  logic [63:0] cyc;
  logic        unused_addr;

  assign ofs         = cfg_bus.addr[7:0];
  assign unused_addr = ^cfg_bus.addr[31:8];
  // A write wins over a simultaneous read; the read is simply dropped.
  assign wr      = cfg_bus.wr;
  assign rd      = cfg_bus.rd && !cfg_bus.wr;
  assign ctrl_wr = wr && (ofs == RR_CTRL_OFS);
  assign clr     = ctrl_wr && cfg_bus.wdata[CTRL_CLR_BIT];

  assign cfg_bus.ack   = ack;
  assign cfg_bus.rdata = rdata;

  rr_sat_counter #(.WIDTH(32)) u_wr_cnt (
    .clk(clk), .sync_rst_n(sync_rst_n), .inc(evt_wr && rr_rec_en), .clr(clr),
    .cnt(wr_cnt), .sat(sats[0]));
  rr_sat_counter #(.WIDTH(32)) u_rd_cnt (
    .clk(clk), .sync_rst_n(sync_rst_n), .inc(evt_rd && rr_rec_en), .clr(clr),
    .cnt(rd_cnt), .sat(sats[1]));
  rr_sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk(clk), .sync_rst_n(sync_rst_n), .inc(log_stall && rr_rec_en), .clr(clr),
    .cnt(stall_cnt), .sat(sats[2]));

  always_comb begin
    rd_mux = RR_BAD_RDATA;
    case (ofs)
      RR_ID_OFS:        rd_mux = ID_VALUE;
      RR_CTRL_OFS:      rd_mux = {30'd0, rr_replay_en, rr_rec_en};
      RR_STATUS_OFS:    rd_mux = {29'd0, sat_flag, rr_replay_en, rr_rec_en};
      RR_SCRATCH_OFS:   rd_mux = scratch;
      RR_WR_CNT_OFS:    rd_mux = wr_cnt;
      RR_RD_CNT_OFS:    rd_mux = rd_cnt;
      RR_STALL_CNT_OFS: rd_mux = stall_cnt;
      RR_CYC_LO_OFS:    rd_mux = cyc[31:0];
      RR_CYC_HI_OFS:    rd_mux = shadow;
      default:          rd_mux = RR_BAD_RDATA;
    endcase
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      ack          <= 1'b0;
      rdata        <= '0;
      rr_rec_en    <= 1'b0;
      rr_replay_en <= 1'b0;
      scratch      <= '0;
    end else begin
      ack <= wr || rd;
      if (rd) rdata <= rd_mux;
      if (ctrl_wr) begin
        // Record takes precedence when both mode bits are written as 1.
        rr_rec_en    <= cfg_bus.wdata[CTRL_REC_BIT];
        rr_replay_en <= cfg_bus.wdata[CTRL_REPLAY_BIT] && !cfg_bus.wdata[CTRL_REC_BIT];
      end
      if (wr && (ofs == RR_SCRATCH_OFS)) scratch <= cfg_bus.wdata;
    end
  end

  // Cycle counter with LO-read snapshot of the upper half for coherent reads.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cyc      <= '0;
      shadow   <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      cyc      <= '0;
      shadow   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (rr_rec_en) cyc <= cyc + 64'd1;
      if (rd && (ofs == RR_CYC_LO_OFS)) shadow <= cyc[63:32];
      sat_flag <= sat_flag || (|sats);
    end
  end
endmodule

// File: tb/tb_rr_cfg_csr.sv
// Directed bench for rr_cfg_csr with a read-data scoreboard checked on ack.
module tb_rr_cfg_csr;
  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    bit   [127:0] tag;
  } sb_t;

  logic clk = 1'b0;
  logic sync_rst_n = 1'b0;
  logic evt_wr = 1'b0, evt_rd = 1'b0, log_stall = 1'b0;
  logic rr_rec_en, rr_replay_en;
  logic exp_ack;
  int   tests = 0, fails = 0;
  sb_t  sb[$];

  cfg_bus_t bus();

  rr_cfg_csr dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .cfg_bus(bus),
    .evt_wr(evt_wr), .evt_rd(evt_rd), .log_stall(log_stall),
    .rr_rec_en(rr_rec_en), .rr_replay_en(rr_replay_en));

  always #5 clk = ~clk;

  task automatic chk(input bit [127:0] tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %0s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit [127:0] tag);
    bus.wr    = w;
    bus.rd    = r;
    bus.addr  = {24'hABCDEF, a};
    bus.wdata = d;
    sb.push_back('{is_rd: (r && !w), exp: exp, tag: tag});
    @(negedge clk);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    req(1'b1, 1'b0, a, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input bit [127:0] tag);
    req(1'b0, 1'b1, a, 32'h0, exp, tag);
  endtask

  // Every request must be acked exactly one cycle later, and only then.
  always @(posedge clk or negedge sync_rst_n)
    if (!sync_rst_n) exp_ack <= 1'b0;
    else             exp_ack <= bus.wr || bus.rd;

  always @(negedge clk) begin
    if (sync_rst_n) begin
      if (exp_ack || bus.ack) chk("ack", bus.ack, exp_ack);
      if (bus.ack) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          sb_t e;
          e = sb.pop_front();
          if (e.is_rd) chk(e.tag, bus.rdata, e.exp);
        end
      end
    end
  end

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rec", rr_rec_en, 0);
    chk("rst_replay", rr_replay_en, 0);
    sync_rst_n = 1'b1;
    @(negedge clk);

    rd(8'h00, 32'h5252_0001, "id");
    rd(8'h04, 32'h0, "ctrl0");
    rd(8'h08, 32'h0, "status0");
    rd(8'h0C, 32'h0, "scratch0");
    rd(8'h1C, 32'h0, "cyclo0");
    wr(8'h0C, 32'hA5A5_5A5A);
    rd(8'h0C, 32'hA5A5_5A5A, "scratch");
    wr(8'h44, 32'h1234_5678);
    rd(8'h44, 32'hDEAD_BEEF, "bad_ofs");
    wr(8'h00, 32'h0);
    rd(8'h00, 32'h5252_0001, "id_ro");
    req(1'b1, 1'b1, 8'h0C, 32'h0BAD_F00D, 32'h0, "wr_rd");
    rd(8'h0C, 32'h0BAD_F00D, "scratch_wrrd");

    // Count only while recording.
    wr(8'h04, 32'h1);
    chk("rec_on", rr_rec_en, 1);
    for (int i = 0; i < 7; i++) begin
      evt_wr = (i < 5); evt_rd = (i < 3); log_stall = 1'b1;
      @(negedge clk);
    end
    evt_wr = 0; evt_rd = 0; log_stall = 0;
    wr(8'h04, 32'h0);
    chk("rec_off", rr_rec_en, 0);
    evt_wr = 1'b1;
    repeat (4) @(negedge clk);
    evt_wr = 1'b0;
    rd(8'h10, 32'd5, "wr_cnt");
    rd(8'h14, 32'd3, "rd_cnt");
    rd(8'h18, 32'd7, "stall_cnt");

    wr(8'h04, 32'h2);
    chk("replay_on", rr_replay_en, 1);
    rd(8'h08, 32'h2, "status_rp");
    wr(8'h04, 32'h3);
    chk("replay_off", rr_replay_en, 0);
    rd(8'h08, 32'h1, "status_both");
    rd(8'h04, 32'h1, "ctrl_both");
    evt_wr = 1'b1;
    wr(8'h04, 32'h5);
    evt_wr = 1'b0;
    rd(8'h10, 32'd0, "clr_wins");
    rd(8'h08, 32'h1, "status_clr");

    // Saturation from a preloaded counter.
    force dut.u_wr_cnt.cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_wr_cnt.cnt;
    evt_wr = 1'b1;
    repeat (3) @(negedge clk);
    evt_wr = 1'b0;
    rd(8'h10, 32'hFFFF_FFFF, "wr_sat");
    rd(8'h08, 32'h5, "status_sat");
    wr(8'h04, 32'h5);
    rd(8'h08, 32'h1, "sat_clr");
    rd(8'h10, 32'h0, "wr_clr");

    // Coherent 64-bit read across the LO->HI carry.
    force dut.cyc = 64'h0000_0001_FFFF_FFFE;
    @(negedge clk);
    release dut.cyc;
    rd(8'h1C, 32'hFFFF_FFFE, "cyc_lo1");
    rd(8'h20, 32'h0000_0001, "cyc_hi1");
    rd(8'h1C, 32'h0000_0000, "cyc_lo2");
    rd(8'h20, 32'h0000_0002, "cyc_hi2");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
